// File: rtl/data_sram_if.sv
// Data-SRAM request/response channel between the pipeline (master) and a responder (slave).
interface data_sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-strobe word array behind a req/addr_ok, data_ok/rdata channel
// with programmable address-phase and data-phase latency and an in-order response queue.
module data_sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int ADDR_LAT    = 0,
    parameter int DATA_LAT    = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       reset,
    data_sram_if.slave bus,
    output logic       align_err
);
    localparam int LW = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
    localparam int CW = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int QW = $clog2(OUTSTANDING + 1);
    localparam logic [LW-1:0] LAT_MAX  = LW'(ADDR_LAT);
    localparam logic [CW-1:0] CD_INIT  = CW'(DATA_LAT - 1);
    localparam logic [QW-1:0] Q_MAX    = QW'(OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

    logic [31:0]            mem [2**ADDR_WIDTH];
    logic [LW-1:0]          lat_cnt;
    logic [31:0]            q_data [OUTSTANDING];
    logic [CW-1:0]          q_cd [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_vld;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [QW-1:0]          count;
    logic                   accept;
    logic                   pop;
    logic                   misaligned;
    logic [ADDR_WIDTH-1:0]  idx;

    // Upper address bits are dropped, so the array aliases across the byte address space.
    assign idx = bus.addr[ADDR_WIDTH+1:2];

    // Fullness uses the pre-pop count: a full queue blocks accept even in a pop cycle.
    assign bus.addr_ok = !reset && bus.req && (lat_cnt == LAT_MAX) && (count < Q_MAX);
    assign accept      = bus.addr_ok;

    assign pop         = !reset && q_vld[head] && (q_cd[head] == '0);
    assign bus.data_ok = pop;
    assign bus.rdata   = pop ? q_data[head] : '0;

    // Size 3 is illegal and is checked as a word.
    always_comb begin
        case (bus.size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.addr[0];
            default: misaligned = |bus.addr[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.req || accept)
            lat_cnt <= '0;
        else if (lat_cnt != LAT_MAX)
            lat_cnt <= lat_cnt + 1'b1;
    end

    // Array contents survive reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int b = 0; b < 4; b++)
                if (bus.wstrb[b])
                    mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            align_err <= 1'b0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++)
                if (q_vld[i] && q_cd[i] != '0)
                    q_cd[i] <= q_cd[i] - 1'b1;
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= (head == PTR_LAST) ? '0 : head + 1'b1;
            end
            // Read data is the pre-edge array word, so same-edge writes are not visible.
            if (accept) begin
                q_vld[tail]  <= 1'b1;
                q_cd[tail]   <= CD_INIT;
                q_data[tail] <= bus.wr ? '0 : mem[idx];
                tail         <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
                if (misaligned)
                    align_err <= 1'b1;
            end
            count <= count + QW'(accept) - QW'(pop);
        end
    end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave/responder end of the pipeline's data-SRAM request/response channel; the model/controller that the pipeline's load and store traffic talks to.
- Accepts requests on a req/addr_ok handshake and returns in-order responses on data_ok/rdata.
- Backs the channel with a word-organised array that supports byte-strobe writes.
- Programmable address-phase and data-phase latency let the pipeline be exercised under stall conditions.

Parameters:
ADDR_WIDTH, 10, word-address bits; array holds 2^ADDR_WIDTH 32-bit words
ADDR_LAT, 0, cycles addr_ok is withheld after req is first seen (0 = same cycle)
DATA_LAT, 1, cycles from accept edge to data_ok (minimum 1)
OUTSTANDING, 2, maximum accepted-but-unanswered requests (response queue depth)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1 = write, 0 = read
data_sram_size  in  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  in  4  byte write enables; authoritative for writes
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  lane-aligned write data
data_sram_addr_ok  out  1  request accepted this cycle when req is also high
data_sram_data_ok  out  1  one-cycle response pulse
data_sram_rdata  out  32  read data, valid with data_ok
align_err  out  1  sticky misalignment flag

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: addr_ok=0, data_ok=0, rdata=0, align_err=0. The response queue and latency counters are cleared.
- Array contents are not cleared by reset.
- Accept: a request is accepted on a rising edge where req && addr_ok.
- addr_ok is combinational and equals req && (lat_cnt == ADDR_LAT) && (queue count < OUTSTANDING).
- lat_cnt:
  - Increments each cycle req is high and lat_cnt < ADDR_LAT.
  - Clears on accept and whenever req is low.
  - With ADDR_LAT=0, back-to-back accepts every cycle are allowed.
- Indexing: word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing).
- Write:
  - Array bytes whose wstrb bit is set are updated at the accept edge.
  - A queue entry is pushed with rdata=0.
  - wstrb=0 is a legal no-op write that still gets a data_ok.
- Read:
  - The word is sampled from the array at the accept edge, with the full 32 bits returned.
  - Lane extraction and sign extension stay with the requester.
  - The value reflects all writes accepted in earlier cycles.
- Queue entry: {rdata, countdown}, countdown initialised to DATA_LAT-1.
- Countdowns of all valid entries decrement each cycle down to 0.
- Response: in a cycle where the head entry has countdown 0, data_ok=1 and rdata=head data; the head pops on that edge.
  - Accept in cycle T gives data_ok in cycle T+DATA_LAT when not blocked by an older head.
  - Responses are strictly in acceptance order.
  - At most one data_ok per cycle.
  - No backpressure on data_ok.
- Simultaneous pop and push in one cycle are both honoured.
  - In that cycle, count < OUTSTANDING is evaluated on the pre-pop count. A full queue therefore blocks accept even if a pop occurs that cycle.
- align_err: set at accept when size=1 && addr[0]!=0, or when size=2 && addr[1:0]!=0. The request still executes. The flag clears only on reset.
- Illegal size=3 is treated as word for the alignment check.
- Reset mid-operation:
  - Pending responses are discarded and no data_ok is emitted after reset.
  - Writes already accepted remain in the array.
- req dropping before accept clears lat_cnt; this must not corrupt state.

Test Plan:
1. ADDR_LAT=0, DATA_LAT=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF at T; read 0x10 at T+1 -> data_ok at T+1 (write) and at T+2 with rdata=0xDEADBEEF.
2. Byte merge: write 0x11223344 (wstrb F) to 0x20, then write 0x0000AA00 with wstrb 4'b0010 -> read 0x20 returns 0x1122AA44.
3. ADDR_LAT=2: hold req from cycle T -> addr_ok first high at T+2. Drop req at T+1 and re-raise at T+3 -> addr_ok at T+5.
4. DATA_LAT=3, OUTSTANDING=2, three back-to-back reads -> third addr_ok deasserted until first data_ok. data_ok pulses occur in order with the correct rdata for each.
5. Half read at addr 0x21 -> align_err=1 and stays set. The data_ok still arrives with the word at 0x20.
6. Reset asserted one cycle after accepting a read with DATA_LAT=2 -> no data_ok, all outputs 0. A read issued after reset returns the pre-reset written data.
